status_register: RTL and testbench
==================================

Name: status_register

Overview:
- Architectural NZCV status register.
- Sits between the EXE-stage ALU and the ID-stage condition checker.
- Captures ALU flags when a flag-setting (S-bit) instruction completes EXE, and supplies the 4-bit condition state {N,Z,C,V} consumed by the condition checker.
- Provides a one-entry shadow (save/restore) for exception entry/return, and either a forwarding path or a hazard signal, selected by parameter.

Parameters:
- FORWARD, 1: 1 = bypass the EXE flag result to cond_state in the same cycle; 0 = no bypass, raise hazard instead.
- SHADOW_EN, 1: 1 = shadow register implemented; 0 = save/restore ignored, shadow_q tied to 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- exe_valid  in  1  EXE stage holds a valid instruction.
- exe_s  in  1  EXE instruction sets flags (S bit) and passed its condition.
- alu_status  in  4  ALU flags {N,Z,C,V}, bit 3 = N, bit 2 = Z, bit 1 = C, bit 0 = V.
- flush  in  1  kill EXE instruction this cycle (branch taken / exception).
- id_valid  in  1  ID stage holds a valid instruction.
- id_cond  in  4  condition field of the ID instruction.
- save  in  1  copy the current flags into the shadow.
- restore  in  1  copy the shadow into the flags.
- cond_state  out  4  flags presented to the condition checker, same bit order as alu_status.
- status_q  out  4  architectural register value.
- shadow_q  out  4  shadow register value.
- hazard  out  1  ID must stall one cycle (FORWARD=0 only).

Behaviour:
- Reset (rst low, asynchronous, any time including mid-update): status_q=0000, shadow_q=0000. cond_state and hazard are combinational from the cleared state and inputs.
- wr = exe_valid & exe_s & ~flush. A flushed EXE instruction never updates flags.
- rs = restore & SHADOW_EN; sv = save & SHADOW_EN.
- status_q next-state priority, evaluated at each rising clk:
  - rs: status_q <= shadow_q.
  - else wr: status_q <= alu_status.
  - else hold.
- shadow_q next-state:
  - sv: shadow_q <= status_q (pre-edge value).
  - else hold.
- sv & rs in the same cycle swaps status_q and shadow_q atomically.
- sv & wr, no rs: shadow_q gets the old status_q and status_q gets alu_status.
- cond_state with FORWARD=1: rs ? shadow_q : wr ? alu_status : status_q. Zero-latency view of the next-state value.
- cond_state with FORWARD=0: equals status_q.
- hazard with FORWARD=0: id_valid & wr & (id_cond != 4'b1110) & (id_cond != 4'b1111).
  - Asserted for exactly the cycle in which the write is in EXE.
  - The next cycle, status_q holds the new flags and hazard drops (unless a new wr arrives).
  - Restore does not raise hazard. Exception return flushes the pipeline.
- hazard with FORWARD=1: constant 0.
- Latency: flag write to status_q is 1 cycle. Flag write to cond_state is 0 cycles (FORWARD=1) or 1 cycle (FORWARD=0).
- Back-to-back flag writes: each cycle's alu_status is taken. The last one wins; there is no accumulation.
- No X propagation: alu_status is ignored when wr=0.

Decomposition:
- Shared package (ARM defines):
  - Flag bit indices: FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - COND_AL=4'b1110, COND_NV=4'b1111.
  - NZCV width constant = 4.
  - The condition checker uses the same constants.
- One natural sub-module: nzcv_reg, a 4-bit async-active-low-reset register with load enable. Instantiate it twice, once for status and once for shadow.
- Forwarding and hazard logic stays in the top level.

Test Plan:
- Reset: rst low mid-run with status_q=1010 -> status_q=0000 and shadow_q=0000 immediately, before any clk edge; cond_state=0000.
- Write/forward: FORWARD=1, exe_valid=1, exe_s=1, alu_status=0100 -> cond_state=0100 in the same cycle, status_q=0100 after the edge.
- Flush: exe_valid=1, exe_s=1, flush=1, alu_status=1111 -> status_q unchanged (0100), cond_state=0100.
- Hazard: FORWARD=0, wr with alu_status=0010, id_valid=1, id_cond=0010 -> hazard=1 for one cycle, then cond_state=0010 and hazard=0. With id_cond=1110, hazard=0.
- Save/restore: status_q=1001, save=1 -> shadow_q=1001. Next, wr alu_status=0110 -> status_q=0110. Then restore=1 with wr alu_status=1111 -> status_q=1001 (restore wins), cond_state=1001 in the restore cycle.
- Swap: status_q=0011, shadow_q=1100, save=1 and restore=1 -> status_q=1100, shadow_q=0011.

Source files
------------

// File: rtl/status_register_pkg.sv
// Shared ARM status definitions: flag positions, unconditional condition codes
// and the NZCV word type. The condition checker uses the same package.
package status_register_pkg;

  localparam int NZCV_W = 4;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  typedef logic [NZCV_W-1:0] nzcv_t;

  // AL and NV never look at the flags, so they never need to wait for them.
  function automatic logic cond_needs_flags(input logic [3:0] cond);
    return (cond != COND_AL) && (cond != COND_NV);
  endfunction

endpackage

// File: rtl/nzcv_reg.sv
// 4-bit flag register with load enable and asynchronous active-low clear.
module nzcv_reg
  import status_register_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  nzcv_t d,
  output nzcv_t q
);

  nzcv_t q_q;

  // Capture d on load; a low rst clears immediately, independent of clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else if (load) begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/status_register.sv
// Architectural NZCV register between the EXE-stage ALU and the ID-stage
// condition checker, with a one-entry shadow for exception entry/return and
// either a same-cycle bypass (FORWARD=1) or a one-cycle stall (FORWARD=0).
module status_register
  import status_register_pkg::*;
#(
  parameter bit FORWARD   = 1'b1,
  parameter bit SHADOW_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       exe_valid,
  input  logic       exe_s,
  input  logic [3:0] alu_status,
  input  logic       flush,
  input  logic       id_valid,
  input  logic [3:0] id_cond,
  input  logic       save,
  input  logic       restore,
  output logic [3:0] cond_state,
  output logic [3:0] status_q,
  output logic [3:0] shadow_q,
  output logic       hazard
);

  logic  wr;
  logic  rs;
  logic  sv;
  nzcv_t status_d;

  assign wr = exe_valid & exe_s & ~flush;
  assign rs = restore & SHADOW_EN;
  assign sv = save & SHADOW_EN;

  // Restore outranks a flag write in the same cycle; this is also exactly the
  // value the register will hold after the edge, which the bypass relies on.
  always_comb begin
    status_d = alu_status;
    if (rs) begin
      status_d = shadow_q;
    end
  end

  nzcv_reg u_status (
    .clk  (clk),
    .rst  (rst),
    .load (rs | wr),
    .d    (status_d),
    .q    (status_q)
  );

  // Shadow always takes the pre-edge status, so save+restore is a clean swap.
  generate
    if (SHADOW_EN) begin : g_shadow
      nzcv_reg u_shadow (
        .clk  (clk),
        .rst  (rst),
        .load (sv),
        .d    (status_q),
        .q    (shadow_q)
      );
    end else begin : g_no_shadow
      assign shadow_q = '0;
    end
  endgenerate

  // Bypass shows next-state flags at zero latency; without it ID reads the
  // register and must stall while a write sits in EXE. Restore never stalls
  // because exception return flushes the pipeline anyway.
  assign cond_state = FORWARD ? status_d & {NZCV_W{rs | wr}} | status_q & {NZCV_W{~(rs | wr)}}
                              : status_q;
  assign hazard     = FORWARD ? 1'b0
                              : (id_valid & wr & cond_needs_flags(id_cond));

endmodule

// File: tb/tb_status_register.sv
// Scoreboard bench for status_register: three instances (bypass, stall,
// no-shadow) share stimulus; a driver pushes expectations from a reference
// model and a monitor pops and compares on the falling edge.
module tb_status_register;

  typedef struct packed {
    logic [3:0] cond;
    logic       haz;
    logic [3:0] st;
    logic [3:0] sh;
  } exp_t;

  localparam bit FWD [3] = '{1'b1, 1'b0, 1'b1};
  localparam bit SHE [3] = '{1'b1, 1'b1, 1'b0};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       exe_valid = 1'b0;
  logic       exe_s = 1'b0;
  logic [3:0] alu_status = 4'd0;
  logic       flush = 1'b0;
  logic       id_valid = 1'b0;
  logic [3:0] id_cond = 4'd0;
  logic       save = 1'b0;
  logic       restore = 1'b0;

  logic [3:0] cond_w   [3];
  logic [3:0] status_w [3];
  logic [3:0] shadow_w [3];
  logic       hazard_w [3];

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int m_st [3];
  int m_sh [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  status_register #(.FORWARD(1'b1), .SHADOW_EN(1'b1)) dut_fwd (
    .clk(clk), .rst(rst), .exe_valid(exe_valid), .exe_s(exe_s),
    .alu_status(alu_status), .flush(flush), .id_valid(id_valid),
    .id_cond(id_cond), .save(save), .restore(restore),
    .cond_state(cond_w[0]), .status_q(status_w[0]),
    .shadow_q(shadow_w[0]), .hazard(hazard_w[0]));

  status_register #(.FORWARD(1'b0), .SHADOW_EN(1'b1)) dut_stall (
    .clk(clk), .rst(rst), .exe_valid(exe_valid), .exe_s(exe_s),
    .alu_status(alu_status), .flush(flush), .id_valid(id_valid),
    .id_cond(id_cond), .save(save), .restore(restore),
    .cond_state(cond_w[1]), .status_q(status_w[1]),
    .shadow_q(shadow_w[1]), .hazard(hazard_w[1]));

  status_register #(.FORWARD(1'b1), .SHADOW_EN(1'b0)) dut_noshd (
    .clk(clk), .rst(rst), .exe_valid(exe_valid), .exe_s(exe_s),
    .alu_status(alu_status), .flush(flush), .id_valid(id_valid),
    .id_cond(id_cond), .save(save), .restore(restore),
    .cond_state(cond_w[2]), .status_q(status_w[2]),
    .shadow_q(shadow_w[2]), .hazard(hazard_w[2]));

  // Apply one cycle of stimulus just after the rising edge, record what each
  // instance must show during this cycle, then advance the model to the
  // values it will hold after the next edge.
  task automatic drive(input logic r, input logic ev, input logic es,
                       input logic [3:0] alu, input logic fl, input logic idv,
                       input logic [3:0] idc, input logic s, input logic rr);
    exp_t e;
    int   w, rsv, svv, uses_flags;
    @(posedge clk);
    #1;
    rst = r; exe_valid = ev; exe_s = es; alu_status = alu; flush = fl;
    id_valid = idv; id_cond = idc; save = s; restore = rr;
    w = (ev && es && !fl) ? 1 : 0;
    uses_flags = (idc == 4'd14 || idc == 4'd15) ? 0 : 1;
    for (int i = 0; i < 3; i++) begin
      rsv = (rr && SHE[i]) ? 1 : 0;
      svv = (s && SHE[i]) ? 1 : 0;
      if (!r) begin
        m_st[i] = 0;
        m_sh[i] = 0;
      end
      e.st = 4'(m_st[i]);
      e.sh = 4'(m_sh[i]);
      if (!FWD[i])       e.cond = 4'(m_st[i]);
      else if (rsv != 0) e.cond = 4'(m_sh[i]);
      else if (w != 0)   e.cond = alu;
      else               e.cond = 4'(m_st[i]);
      e.haz = (!FWD[i] && idv && w != 0 && uses_flags != 0);
      if (i == 0) q0.push_back(e);
      else if (i == 1) q1.push_back(e);
      else q2.push_back(e);
      if (r) begin
        int old_st;
        old_st = m_st[i];
        if (rsv != 0)    m_st[i] = m_sh[i];
        else if (w != 0) m_st[i] = int'(alu);
        if (svv != 0)    m_sh[i] = old_st;
      end
    end
  endtask

  task automatic chk4(input string nm, input int inst, input logic [3:0] act,
                      input logic [3:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s inst%0d t=%0t: got %b want %b", nm, inst, $time, act, exp_v);
    end
  endtask

  // Monitor: every cycle each instance presents a result; pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if ((i == 0 && q0.size() > 0) || (i == 1 && q1.size() > 0) ||
            (i == 2 && q2.size() > 0)) begin
          if (i == 0) e = q0.pop_front();
          else if (i == 1) e = q1.pop_front();
          else e = q2.pop_front();
          chk4("cond_state", i, cond_w[i], e.cond);
          chk4("status_q", i, status_w[i], e.st);
          chk4("shadow_q", i, shadow_w[i], e.sh);
          chk4("hazard", i, {3'b000, hazard_w[i]}, {3'b000, e.haz});
        end
      end
    end
  end

  // Stimulus: directed test-plan sequences followed by randomized traffic.
  initial begin
    logic r, ev, es, fl, idv, s, rr;
    logic [3:0] alu, idc;
    for (int i = 0; i < 3; i++) begin
      m_st[i] = 0;
      m_sh[i] = 0;
    end
    drive(0, 0, 0, 4'h0, 0, 0, 4'h0, 0, 0);
    drive(0, 0, 0, 4'h0, 0, 0, 4'h0, 0, 0);
    drive(1, 0, 0, 4'h0, 0, 0, 4'h0, 0, 0);
    // async reset from status 1010
    drive(1, 1, 1, 4'b1010, 0, 0, 4'h0, 1, 0);
    drive(1, 1, 1, 4'b1010, 0, 0, 4'h0, 0, 0);
    drive(0, 0, 0, 4'h0, 0, 0, 4'h0, 0, 0);
    drive(1, 0, 0, 4'h0, 0, 0, 4'h0, 0, 0);
    // write/forward then flush
    drive(1, 1, 1, 4'b0100, 0, 0, 4'h0, 0, 0);
    drive(1, 1, 1, 4'b1111, 1, 0, 4'h0, 0, 0);
    drive(1, 0, 1, 4'b1011, 0, 0, 4'h0, 0, 0);
    drive(1, 1, 0, 4'b1011, 0, 0, 4'h0, 0, 0);
    // hazard
    drive(1, 1, 1, 4'b0010, 0, 1, 4'b0010, 0, 0);
    drive(1, 0, 0, 4'h0, 0, 1, 4'b0010, 0, 0);
    drive(1, 1, 1, 4'b0011, 0, 1, 4'b1110, 0, 0);
    drive(1, 1, 1, 4'b0101, 0, 1, 4'b1111, 0, 0);
    drive(1, 1, 1, 4'b0110, 0, 0, 4'b0000, 0, 0);
    // save / write / restore-wins
    drive(1, 1, 1, 4'b1001, 0, 0, 4'h0, 0, 0);
    drive(1, 0, 0, 4'h0, 0, 0, 4'h0, 1, 0);
    drive(1, 1, 1, 4'b0110, 0, 0, 4'h0, 0, 0);
    drive(1, 1, 1, 4'b1111, 0, 1, 4'b0001, 0, 1);
    drive(1, 0, 0, 4'h0, 0, 0, 4'h0, 0, 0);
    // swap
    drive(1, 1, 1, 4'b1100, 0, 0, 4'h0, 0, 0);
    drive(1, 0, 0, 4'h0, 0, 0, 4'h0, 1, 0);
    drive(1, 1, 1, 4'b0011, 0, 0, 4'h0, 0, 0);
    drive(1, 0, 0, 4'h0, 0, 0, 4'h0, 1, 1);
    drive(1, 0, 0, 4'h0, 0, 0, 4'h0, 0, 0);
    for (int n = 0; n < 400; n++) begin
      r   = ($urandom_range(0, 39) != 0);
      ev  = ($urandom_range(0, 3) != 0);
      es  = ($urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 4) == 0);
      alu = 4'($urandom);
      idv = ($urandom_range(0, 3) != 0);
      idc = ($urandom_range(0, 3) == 0) ? 4'(14 + $urandom_range(0, 1)) : 4'($urandom);
      s   = ($urandom_range(0, 5) == 0);
      rr  = ($urandom_range(0, 5) == 0);
      drive(r, ev, es, alu, fl, idv, idc, s, rr);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0",
               q0.size() + q1.size() + q2.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
